// File: rtl/ahb_vga_pkg.sv
// -----------------------------------------------------------------------------
// ahb_vga_pkg
// Shared AHB-Lite encodings and constants for the VGA character master.
//   htrans_t          : HTRANS encodings used by this initiator (IDLE, NONSEQ)
//   HSIZE_WORD        : 32-bit transfer size
//   VGA_CONSOLE_ADDR  : default console write address
//   char_to_wdata()   : places a character code in the low byte of HWDATA
// -----------------------------------------------------------------------------
package ahb_vga_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        NONSEQ = 2'b10
    } htrans_t;

    localparam logic [2:0]  HSIZE_WORD       = 3'b010;
    localparam logic [31:0] VGA_CONSOLE_ADDR = 32'h5000_0000;

    function automatic logic [31:0] char_to_wdata(input logic [7:0] c);
        return {24'h0, c};
    endfunction

endpackage

// File: rtl/ahb_vga_char_master_fifo.sv
// -----------------------------------------------------------------------------
// vga_char_fifo
// Synchronous FIFO holding characters waiting for an AHB address phase.
// Asynchronous active-low reset flushes the pointers and the level.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_push, i_data : write strobe and data (ignored while full)
//   i_pop          : read strobe (ignored while empty); o_data is the head
//   o_level        : entries held, 0..DEPTH
//   o_full/o_empty : derived from the registered level
// -----------------------------------------------------------------------------
module vga_char_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == LW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_level   = r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/ahb_vga_char_master.sv
// -----------------------------------------------------------------------------
// ahb_vga_char_master
// AHB-Lite initiator that writes buffered characters to the VGA text console,
// one single-beat NONSEQ word write per character, pipelined so that
// back-to-back writes sustain one per HREADY-high cycle.
// Optional feature (macro AHB_VGA_MASTER_DLS_EN): a shadow copy of the phase
// logic runs in lockstep and any divergence sets a sticky DLS_ERROR; the
// INJECT_BUG port exists only in that build.
// Ports:
//   HCLK, HRESETn         : clock, async active-low reset
//   CHAR_VALID/DATA/READY : character input stream (READY = FIFO not full)
//   HREADY                : shared bus ready
//   HADDR/HTRANS/HWRITE/HSIZE/HWDATA : AHB-Lite master outputs
//   FIFO_LEVEL            : characters waiting in the FIFO
//   BUSY                  : FIFO non-empty or an address/data phase active
//   WR_COUNT              : completed writes, wraps
//   DLS_ERROR             : sticky lockstep mismatch (0 without the macro)
// -----------------------------------------------------------------------------
module ahb_vga_char_master
    import ahb_vga_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = VGA_CONSOLE_ADDR,
    parameter int          CNT_W      = 16
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic                          CHAR_VALID,
    input  logic [7:0]                    CHAR_DATA,
    output logic                          CHAR_READY,
    input  logic                          HREADY,
    output logic [31:0]                   HADDR,
    output logic [1:0]                    HTRANS,
    output logic                          HWRITE,
    output logic [2:0]                    HSIZE,
    output logic [31:0]                   HWDATA,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic                          BUSY,
    output logic [CNT_W-1:0]              WR_COUNT,
`ifdef AHB_VGA_MASTER_DLS_EN
    input  logic [1:0]                    INJECT_BUG,
`endif
    output logic                          DLS_ERROR
);

`ifdef AHB_VGA_MASTER_DLS_EN
    localparam int N_LANES = 2;
`else
    localparam int N_LANES = 1;
`endif

    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic [7:0] w_head;
    htrans_t    w_htrans;

    assign CHAR_READY = !w_full;
    assign w_push     = CHAR_VALID && !w_full;
    // Pop on every ready edge, or refill an empty address slot during a wait:
    // IDLE may turn into NONSEQ while HREADY is low, but NONSEQ must hold.
    assign w_pop      = !w_empty && (HREADY || !g_lane[0].r_addr_vld);

    vga_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk   (HCLK),
        .i_rst_n (HRESETn),
        .i_push  (w_push),
        .i_data  (CHAR_DATA),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_level (FIFO_LEVEL),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Lane 0 drives the bus; lane 1 (lockstep build only) is the shadow.
    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        logic             r_addr_vld;
        logic [7:0]       r_addr_char;
        logic             r_data_vld;
        logic [7:0]       r_data_char;
        logic [CNT_W-1:0] r_wr_count;

        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                r_addr_vld  <= 1'b0;
                r_addr_char <= '0;
                r_data_vld  <= 1'b0;
                r_data_char <= '0;
                r_wr_count  <= '0;
            end else begin
                // Address phase
                if (w_pop) begin
                    r_addr_vld  <= 1'b1;
                    r_addr_char <= w_head;
                end else if (HREADY) begin
                    r_addr_vld  <= 1'b0;
                end
                // Data phase; a write completes on the ready edge ending it
                if (HREADY) begin
                    r_data_vld  <= r_addr_vld;
                    r_data_char <= r_addr_char;
                    if (r_data_vld) r_wr_count <= r_wr_count + CNT_W'(1);
                end
            end
        end
    end

    assign w_htrans = g_lane[0].r_addr_vld ? NONSEQ : IDLE;
    assign HTRANS   = w_htrans;
    assign HWRITE   = g_lane[0].r_addr_vld;
    assign HADDR    = BASE_ADDR;
    assign HSIZE    = HSIZE_WORD;
    assign HWDATA   = char_to_wdata(g_lane[0].r_data_char);
    assign WR_COUNT = g_lane[0].r_wr_count;
    assign BUSY     = (FIFO_LEVEL != '0) || g_lane[0].r_addr_vld || g_lane[0].r_data_vld;

`ifdef AHB_VGA_MASTER_DLS_EN
    logic w_mismatch;
    logic r_dls_error;

    assign w_mismatch =
        (g_lane[0].r_addr_vld  != (g_lane[1].r_addr_vld ^ INJECT_BUG[0])) ||
        (g_lane[0].r_addr_char !=  g_lane[1].r_addr_char)                 ||
        (g_lane[0].r_data_vld  !=  g_lane[1].r_data_vld)                  ||
        (g_lane[0].r_data_char != (g_lane[1].r_data_char ^ {7'b0, INJECT_BUG[1]})) ||
        (g_lane[0].r_wr_count  !=  g_lane[1].r_wr_count);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_dls_error <= 1'b0;
        else          r_dls_error <= r_dls_error | w_mismatch;
    end

    assign DLS_ERROR = r_dls_error;
`else
    assign DLS_ERROR = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_vga_char_master.sv
// -----------------------------------------------------------------------------
// tb_ahb_vga_char_master
// Bench for ahb_vga_char_master. A bus-level scoreboard follows the AHB
// transfers: accepted characters queue up in order, and every write that
// completes on a ready edge must carry the oldest outstanding character.
// Directed scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_ahb_vga_char_master;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h5000_0000;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        CHAR_VALID = 1'b0;
    logic [7:0]  CHAR_DATA = 8'h00;
    logic        CHAR_READY;
    logic        HREADY = 1'b1;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [4:0]  FIFO_LEVEL;
    logic        BUSY;
    logic [15:0] WR_COUNT;
    logic        DLS_ERROR;
`ifdef AHB_VGA_MASTER_DLS_EN
    logic [1:0]  INJECT_BUG = 2'b00;
`endif

    ahb_vga_char_master #(
        .FIFO_DEPTH (DEPTH),
        .BASE_ADDR  (BASE),
        .CNT_W      (16)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .CHAR_VALID (CHAR_VALID),
        .CHAR_DATA  (CHAR_DATA),
        .CHAR_READY (CHAR_READY),
        .HREADY     (HREADY),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HWDATA     (HWDATA),
        .FIFO_LEVEL (FIFO_LEVEL),
        .BUSY       (BUSY),
        .WR_COUNT   (WR_COUNT),
`ifdef AHB_VGA_MASTER_DLS_EN
        .INJECT_BUG (INJECT_BUG),
`endif
        .DLS_ERROR  (DLS_ERROR)
    );

    always #5 HCLK = ~HCLK;

    int          n_chk = 0;
    int          n_bad = 0;
    byte unsigned q_exp[$];   // accepted characters not yet written
    bit          dpend = 1'b0; // a write is in its data phase
    int          n_done = 0;  // writes completed since reset
    bit          dls_exp = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: called at a negedge, drives inputs, lets the posedge
    // happen, and checks the outputs at the following negedge.
    task automatic step(input bit v, input logic [7:0] d, input bit rdy);
        logic        pre_ready;
        logic [4:0]  pre_level;
        logic [1:0]  pre_trans;
        logic [31:0] pre_wdata;
        logic [31:0] pre_haddr;
        byte unsigned e;
        CHAR_VALID = v;
        CHAR_DATA  = d;
        HREADY     = rdy;
        pre_ready  = CHAR_READY;
        pre_level  = FIFO_LEVEL;
        pre_trans  = HTRANS;
        pre_wdata  = HWDATA;
        pre_haddr  = HADDR;
`ifdef AHB_VGA_MASTER_DLS_EN
        if (INJECT_BUG != 2'b00) dls_exp = 1'b1;
`endif
        @(posedge HCLK);
        @(negedge HCLK);
        if (rdy) begin
            if (dpend) begin
                check_val("wr_has_char", q_exp.size() > 0, 1);
                if (q_exp.size() > 0) begin
                    e = q_exp.pop_front();
                    check_val("wdata", pre_wdata, {24'h0, e});
                end
                n_done++;
            end
            dpend = (pre_trans == 2'b10);
            if (dpend) check_val("haddr", pre_haddr, BASE);
        end else begin
            if (dpend) check_val("wdata_hold", HWDATA, pre_wdata);
            if (pre_trans == 2'b10) begin
                check_val("htrans_hold", HTRANS, 2'b10);
                check_val("haddr_hold", HADDR, pre_haddr);
            end
        end
        if (v && pre_ready) q_exp.push_back(d);
        check_val("ready_vs_level", pre_ready, pre_level != DEPTH);
        check_val("wr_count", WR_COUNT, n_done & 16'hFFFF);
        if (pre_level != 0) check_val("issue_when_queued", HTRANS, 2'b10);
        check_val("in_flight", int'(FIFO_LEVEL) + int'(HTRANS == 2'b10) + int'(dpend), q_exp.size());
        check_val("hwrite", HWRITE, HTRANS == 2'b10);
        check_val("hsize", HSIZE, 3'b010);
        check_val("busy", BUSY, (FIFO_LEVEL != 0) || (HTRANS == 2'b10) || dpend);
        check_val("dls", DLS_ERROR, dls_exp);
    endtask

    // Asynchronous reset pulse; the outputs must clear before any clock edge.
    task automatic do_reset();
        HRESETn = 1'b0;
        #1;
        check_val("rst_htrans", HTRANS, 2'b00);
        check_val("rst_hwrite", HWRITE, 1'b0);
        check_val("rst_haddr", HADDR, BASE);
        check_val("rst_hwdata", HWDATA, 32'h0);
        check_val("rst_level", FIFO_LEVEL, 0);
        check_val("rst_wr_count", WR_COUNT, 0);
        check_val("rst_busy", BUSY, 1'b0);
        check_val("rst_dls", DLS_ERROR, 1'b0);
        q_exp.delete();
        dpend   = 1'b0;
        n_done  = 0;
        dls_exp = 1'b0;
        CHAR_VALID = 1'b0;
        HREADY     = 1'b1;
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  hello [5];
        logic [1:0]  tr [10];
        logic [31:0] wd [10];
        logic        bz [10];
        logic [15:0] wc [10];
        logic [7:0]  ch;
        int          guard;

        hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;

        repeat (3) @(negedge HCLK);
        do_reset();
        step(1'b0, 8'h00, 1'b1);
        check_val("ready_after_rst", CHAR_READY, 1'b1);

        // Single character latency
        step(1'b1, 8'h41, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check_val("single_nonseq", HTRANS, 2'b10);
        check_val("single_haddr", HADDR, 32'h5000_0000);
        check_val("single_hwrite", HWRITE, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check_val("single_hwdata", HWDATA, 32'h41);
        step(1'b0, 8'h00, 1'b1);
        check_val("single_count", WR_COUNT, 16'd1);

        // "HELLO" burst at full throughput
        for (int c = 1; c <= 9; c++) begin
            ch = 8'h00;
            if (c <= 5) ch = hello[c-1];
            step(c <= 5, ch, 1'b1);
            tr[c] = HTRANS; wd[c] = HWDATA; bz[c] = BUSY; wc[c] = WR_COUNT;
        end
        for (int c = 2; c <= 6; c++) check_val("burst_nonseq", tr[c], 2'b10);
        check_val("burst_idle_after", tr[7], 2'b00);
        for (int k = 0; k < 5; k++) check_val("burst_hwdata", wd[3+k], {24'h0, hello[k]});
        check_val("burst_busy_last", bz[7], 1'b1);
        check_val("burst_busy_fall", bz[8], 1'b0);
        check_val("burst_count", wc[8], 16'd6);

        // Wait states during the second address phase
        step(1'b1, 8'h61, 1'b1);
        step(1'b1, 8'h62, 1'b1);
        step(1'b1, 8'h63, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b0);
            check_val("wait_htrans", HTRANS, 2'b10);
            check_val("wait_haddr", HADDR, BASE);
            check_val("wait_hwdata", HWDATA, 32'h61);
            check_val("wait_no_pop", FIFO_LEVEL, 5'd1);
        end
        repeat (6) step(1'b0, 8'h00, 1'b1);

        // Fill the FIFO while the bus is stalled
        for (int i = 0; i < 20; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0);
        check_val("fill_level", FIFO_LEVEL, 5'd16);
        check_val("fill_ready", CHAR_READY, 1'b0);
        check_val("fill_accepted", q_exp.size(), 17);
        guard = 0;
        while (BUSY && guard < 60) begin
            step(1'b0, 8'h00, 1'b1);
            guard++;
        end
        check_val("drain_done", BUSY, 1'b0);
        check_val("drain_ready", CHAR_READY, 1'b1);
        check_val("drain_queue", q_exp.size(), 0);

        // Reset while a transfer is in flight with characters queued
        for (int i = 0; i < 4; i++) step(1'b1, 8'h30 + 8'(i), 1'b0);
        check_val("pre_rst_level", FIFO_LEVEL, 5'd3);
        check_val("pre_rst_nonseq", HTRANS, 2'b10);
        do_reset();
        step(1'b0, 8'h00, 1'b1);
        check_val("post_rst_ready", CHAR_READY, 1'b1);

`ifdef AHB_VGA_MASTER_DLS_EN
        // Lockstep fault injection
        step(1'b1, 8'h5A, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        INJECT_BUG = 2'b10;
        step(1'b0, 8'h00, 1'b1);
        INJECT_BUG = 2'b00;
        check_val("dls_set", DLS_ERROR, 1'b1);
        repeat (4) step(1'b0, 8'h00, 1'b1);
        check_val("dls_sticky", DLS_ERROR, 1'b1);
        do_reset();
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 3) != 0);
        end
        guard = 0;
        while (BUSY && guard < 100) begin
            step(1'b0, 8'h00, 1'b1);
            guard++;
        end
        check_val("rand_drain", BUSY, 1'b0);
        check_val("rand_queue", q_exp.size(), 0);
        check_val("rand_count", WR_COUNT, n_done & 16'hFFFF);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
